// File: rtl/oam_dma_if.sv
// CPU/MMIO bus, shared-memory read port and OAM write port of the OAM DMA sequencer.
// The slave modport is the DMA controller; the master modport is the surrounding system.
interface oam_dma_if;
  logic [15:0] ADDR;
  logic        WR;
  logic        RD;
  logic [7:0]  MMIO_DATA_out;
  logic [7:0]  MMIO_DATA_in;
  logic        DMA_RD;
  logic [15:0] DMA_ADDR;
  logic [7:0]  DMA_DATA_in;
  logic        OAM_WR;
  logic [7:0]  OAM_ADDR;
  logic [7:0]  OAM_DATA;
  logic        DMA_ACTIVE;
  logic        CPU_BLOCK;

  modport master (
    output ADDR, WR, RD, MMIO_DATA_out, DMA_DATA_in,
    input  MMIO_DATA_in, DMA_RD, DMA_ADDR, OAM_WR, OAM_ADDR, OAM_DATA,
           DMA_ACTIVE, CPU_BLOCK
  );

  modport slave (
    input  ADDR, WR, RD, MMIO_DATA_out, DMA_DATA_in,
    output MMIO_DATA_in, DMA_RD, DMA_ADDR, OAM_WR, OAM_ADDR, OAM_DATA,
           DMA_ACTIVE, CPU_BLOCK
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// FF46 OAM DMA sequencer: copies N_BYTES bytes from page SRC into OAM, one byte per
// CYC_PER_BYTE-clock slot, after a one-slot START period. A new FF46 write restarts the copy.
module oam_dma_ctrl #(
  parameter int CYC_PER_BYTE = 4,
  parameter int N_BYTES      = 160
) (
  input logic     clk,
  input logic     rst,
  oam_dma_if.slave bus
);

  localparam int PW = $clog2(CYC_PER_BYTE);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [PW-1:0] P_PRE  = PW'(CYC_PER_BYTE - 2);
  localparam logic [PW-1:0] P_LAST = PW'(CYC_PER_BYTE - 1);
  localparam logic [7:0]    IDX_LAST = 8'(N_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    dma_reg;
  logic [7:0]    src;
  logic [7:0]    idx;
  logic [PW-1:0] phase;
  logic [7:0]    data;
  logic          dma_rd;
  logic [15:0]   dma_addr;
  logic          oam_wr;
  logic [7:0]    oam_addr;
  logic          active;

  logic          trigger;
  logic [7:0]    src_next;
  logic [7:0]    mmio_rdata;
  logic          cpu_block;

  // Decode the FF46 write and fold E0..FF source pages down into the C0..DF echo range.
  always_comb begin
    trigger = bus.WR && (bus.ADDR == 16'hFF46);
    if (bus.MMIO_DATA_out >= 8'hE0) begin
      src_next = bus.MMIO_DATA_out & 8'hDF;
    end else begin
      src_next = bus.MMIO_DATA_out;
    end
  end

  // Sequencer: START slot, then per byte read at phase 0, latch at phase 1, write at last phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dma_reg  <= 8'hFF;
      src      <= 8'h00;
      idx      <= 8'd0;
      phase    <= '0;
      data     <= 8'h00;
      dma_rd   <= 1'b0;
      dma_addr <= 16'h0000;
      oam_wr   <= 1'b0;
      oam_addr <= 8'd0;
      active   <= 1'b0;
    end else begin
      dma_rd <= 1'b0;
      oam_wr <= 1'b0;
      if (trigger) begin
        // A write in any state (re)starts the copy; a pending write for the aborted byte is dropped.
        dma_reg <= bus.MMIO_DATA_out;
        src     <= src_next;
        state   <= START;
        idx     <= 8'd0;
        phase   <= '0;
        active  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            phase <= '0;
            idx   <= 8'd0;
          end
          START: begin
            if (phase == P_LAST) begin
              phase    <= '0;
              state    <= XFER;
              dma_rd   <= 1'b1;
              dma_addr <= {src, idx};
            end else begin
              phase <= phase + 1'b1;
            end
          end
          XFER: begin
            if (phase == P_ONE) begin
              data <= bus.DMA_DATA_in;
            end
            if (phase == P_PRE) begin
              oam_wr   <= 1'b1;
              oam_addr <= idx;
            end
            if (phase == P_LAST) begin
              phase <= '0;
              if (idx == IDX_LAST) begin
                state  <= IDLE;
                idx    <= 8'd0;
                active <= 1'b0;
              end else begin
                idx      <= idx + 8'd1;
                dma_rd   <= 1'b1;
                dma_addr <= {src, idx + 8'd1};
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            phase  <= '0;
            idx    <= 8'd0;
            active <= 1'b0;
          end
        endcase
      end
    end
  end

  // FF46 read-back and CPU lock-out of everything below the high page while a copy runs.
  always_comb begin
    if (bus.RD && (bus.ADDR == 16'hFF46)) begin
      mmio_rdata = dma_reg;
    end else begin
      mmio_rdata = 8'h00;
    end
    cpu_block = active && (bus.ADDR < 16'hFF00);
  end

  assign bus.MMIO_DATA_in = mmio_rdata;
  assign bus.CPU_BLOCK    = cpu_block;
  assign bus.DMA_RD       = dma_rd;
  assign bus.DMA_ADDR     = dma_addr;
  assign bus.OAM_WR       = oam_wr;
  assign bus.OAM_ADDR     = oam_addr;
  assign bus.OAM_DATA     = data;
  assign bus.DMA_ACTIVE   = active;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: a transfer-level model turns each FF46 write into the
// expected stream of source reads and OAM writes (by clock edge); a negedge monitor compares.
module tb_oam_dma_ctrl;

  localparam int C = 4;
  localparam int N = 160;

  typedef struct {
    longint     at_edge;
    logic [7:0] idx;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    longint      at_edge;
    logic [15:0] addr;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  oam_dma_if bus ();

  oam_dma_ctrl #(.CYC_PER_BYTE(C), .N_BYTES(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint start_e = 0;
  longint busy_end = 0;
  logic [7:0] reg_model = 8'hFF;
  wr_t    wq[$];
  rd_t    rq[$];

  // Source memory contents depend on both address bytes so a wrong page shows up in OAM data.
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Memory responder: data for a read request appears during the following clock.
  always @(posedge clk) begin
    logic        r;
    logic [15:0] a;
    r = bus.DMA_RD;
    a = bus.DMA_ADDR;
    #1;
    bus.DMA_DATA_in = r ? mem(a) : 8'($urandom);
  end

  // Reference model: a copy is a schedule of reads/writes relative to the trigger edge.
  always @(posedge clk) begin
    logic [7:0] d;
    logic [7:0] s;
    cyc++;
    if (rst) begin
      reg_model = 8'hFF;
      busy_end  = 0;
      while (wq.size() > 0 && wq[$].at_edge > cyc) void'(wq.pop_back());
      while (rq.size() > 0 && rq[$].at_edge > cyc) void'(rq.pop_back());
    end else if (bus.WR && bus.ADDR == 16'hFF46) begin
      d = bus.MMIO_DATA_out;
      s = (d >= 8'hE0) ? (d - 8'h20) : d;
      reg_model = d;
      while (wq.size() > 0 && wq[$].at_edge > cyc) void'(wq.pop_back());
      while (rq.size() > 0 && rq[$].at_edge > cyc) void'(rq.pop_back());
      for (int k = 0; k < N; k++) begin
        rq.push_back('{cyc + (k + 1) * C + 1, {s, 8'(k)}});
        wq.push_back('{cyc + (k + 2) * C, 8'(k), mem({s, 8'(k)})});
      end
      start_e  = cyc;
      busy_end = cyc + (N + 1) * C;
    end
  end

  // Monitor: every cycle compare status outputs, and compare each strobe against the queues.
  always @(negedge clk) begin
    logic exp_act;
    logic exp_wr;
    logic exp_rd;
    if (cyc >= 1) begin
      exp_act = (cyc >= start_e) && (cyc < busy_end);
      chk("dma_active", 16'(bus.DMA_ACTIVE), 16'(exp_act));
      chk("cpu_block", 16'(bus.CPU_BLOCK), 16'(exp_act && bus.ADDR < 16'hFF00));
      chk("mmio_read", 16'(bus.MMIO_DATA_in),
          (bus.RD && bus.ADDR == 16'hFF46) ? 16'(reg_model) : 16'h0000);
      while (wq.size() > 0 && wq[0].at_edge <= cyc) begin
        chk("oam_wr_missed", 16'(wq[0].idx), 16'hFFFF);
        void'(wq.pop_front());
      end
      while (rq.size() > 0 && rq[0].at_edge <= cyc) begin
        chk("dma_rd_missed", rq[0].addr, 16'hFFFF);
        void'(rq.pop_front());
      end
      exp_wr = (wq.size() > 0) && (wq[0].at_edge == cyc + 1);
      if (bus.OAM_WR || exp_wr) begin
        chk("oam_wr", 16'(bus.OAM_WR), 16'(exp_wr));
        if (exp_wr) begin
          if (bus.OAM_WR) begin
            chk("oam_addr", 16'(bus.OAM_ADDR), 16'(wq[0].idx));
            chk("oam_data", 16'(bus.OAM_DATA), 16'(wq[0].data));
          end
          void'(wq.pop_front());
        end
      end
      exp_rd = (rq.size() > 0) && (rq[0].at_edge == cyc + 1);
      if (bus.DMA_RD || exp_rd) begin
        chk("dma_rd", 16'(bus.DMA_RD), 16'(exp_rd));
        if (exp_rd) begin
          if (bus.DMA_RD) chk("dma_addr", bus.DMA_ADDR, rq[0].addr);
          void'(rq.pop_front());
        end
      end
    end
  end

  // Random CPU traffic that never writes FF46.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 5))
        0: bus.ADDR = 16'h8000;
        1: bus.ADDR = 16'hFF80;
        2: bus.ADDR = 16'hFF46;
        3: bus.ADDR = 16'hFEFF;
        4: bus.ADDR = 16'hFF00;
        default: bus.ADDR = 16'($urandom);
      endcase
      bus.RD = 1'($urandom);
      bus.WR = (bus.ADDR == 16'hFF46) ? 1'b0 : 1'($urandom);
      bus.MMIO_DATA_out = 8'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input longint t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic trigger_now(input logic [7:0] d, output longint e);
    bus.ADDR = 16'hFF46;
    bus.WR = 1'b1;
    bus.RD = 1'b0;
    bus.MMIO_DATA_out = d;
    @(posedge clk);
    #1;
    e = cyc;
    bus.WR = 1'b0;
  endtask

  // Stimulus sequence.
  initial begin
    longint e;
    bus.ADDR = 16'h0000;
    bus.WR = 1'b0;
    bus.RD = 1'b0;
    bus.MMIO_DATA_out = 8'h00;
    bus.DMA_DATA_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.RD = 1'b1;
    bus.ADDR = 16'hFF46;
    @(posedge clk);
    #1;
    idle(5);

    // Plain copy from page C1.
    trigger_now(8'hC1, e);
    idle(700);

    // Echo-range page folding, then restart at byte 50.
    trigger_now(8'hE3, e);
    bus.RD = 1'b1;
    bus.ADDR = 16'hFF46;
    wait_to(e + 20);
    wait_to(e + (50 + 2) * C - 3);
    trigger_now(8'h80, e);
    idle(700);

    // Restart on the same edge as the final OAM write.
    trigger_now(8'h12, e);
    wait_to(e + (N + 1) * C - 1);
    trigger_now(8'h34, e);
    idle(700);

    // Reset in the middle of byte 10.
    trigger_now(8'h55, e);
    wait_to(e + (10 + 2) * C - 3);
    bus.WR = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.RD = 1'b1;
    bus.ADDR = 16'hFF46;
    @(posedge clk);
    #1;
    idle(20);

    // Random sources and random restart points.
    for (int i = 0; i < 5; i++) begin
      trigger_now(8'($urandom), e);
      idle($urandom_range(3, 800));
    end
    idle(700);

    chk("wr_queue_drained", 16'(wq.size()), 16'd0);
    chk("rd_queue_drained", 16'(rq.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
